// File: rtl/mem_if_pkg.sv
// Shared types and defaults for the serial memory front end.
// State encoding is fixed so debug probes can decode it directly.
package mem_if_pkg;

   localparam int DATA_W_DEF   = 8;
   localparam int TR_COUNT_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CMD  = 2'b01,
      BITS = 2'b10
   } state_t;

endpackage

// File: rtl/mem_serial_frontend_if.sv
// Serial frame inputs, controller requests and deserialised outputs.
// The slave modport belongs to the front end, the master to its driver.
interface mem_serial_frontend_if #(
   parameter int DATA_W = 8
);

   logic              frame_active;
   logic              sdi;
   logic              sdi_valid;
   logic              tr_clear;
   logic              tr_increament;
   logic [DATA_W-1:0] byte_out;
   logic              shift_en;
   logic              transaction_done;
   logic              tr_done_4;
   logic              read_write;
   logic              busy;

   modport master (
      output frame_active, sdi, sdi_valid, tr_clear, tr_increament,
      input  byte_out, shift_en, transaction_done, tr_done_4,
      input  read_write, busy
   );

   modport slave (
      input  frame_active, sdi, sdi_valid, tr_clear, tr_increament,
      output byte_out, shift_en, transaction_done, tr_done_4,
      output read_write, busy
   );

endinterface

// File: rtl/mem_serial_frontend_tr_counter.sv
// Saturating transaction counter; clear beats increment.
// tr_done is a pure decode of the count register.
module tr_counter #(
   parameter int TR_COUNT = 4,
   parameter int CNT_W    = $clog2(TR_COUNT + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             tr_done
);

   localparam logic [CNT_W-1:0] MAX = CNT_W'(TR_COUNT);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (inc && count != MAX) begin
         count <= count + 1'b1;
      end
   end

   assign tr_done = (count == MAX);

endmodule

// File: rtl/mem_serial_frontend.sv
// Serial frame deserialiser: one command bit, then MSB-first bytes.
// Dropping frame_active mid-frame discards partial data and the count.
module mem_serial_frontend
   import mem_if_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int TR_COUNT = TR_COUNT_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   mem_serial_frontend_if.slave bus
);

   localparam int BC_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int CNT_W = $clog2(TR_COUNT + 1);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

   state_t            state;
   logic [BC_W-1:0]   bit_cnt;
   logic [DATA_W-2:0] shreg;
   logic              abort;
   logic [CNT_W-1:0]  tr_count_unused;

   assign abort = (state != IDLE) && !bus.frame_active;

   tr_counter #(
      .TR_COUNT (TR_COUNT)
   ) u_tr (
      .clk     (clk),
      .reset   (reset),
      .clr     (bus.tr_clear | abort),
      .inc     (bus.tr_increament),
      .count   (tr_count_unused),
      .tr_done (bus.tr_done_4)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state                <= IDLE;
         bit_cnt              <= '0;
         shreg                <= '0;
         bus.byte_out         <= '0;
         bus.shift_en         <= 1'b0;
         bus.transaction_done <= 1'b0;
         bus.read_write       <= 1'b0;
         bus.busy             <= 1'b0;
      end else begin
         bus.shift_en         <= 1'b0;
         bus.transaction_done <= 1'b0;
         case (state)
            IDLE: begin
               bit_cnt <= '0;
               if (bus.frame_active) begin
                  state    <= CMD;
                  bus.busy <= 1'b1;
               end
            end
            CMD: begin
               if (!bus.frame_active) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end else if (bus.sdi_valid) begin
                  bus.read_write <= bus.sdi;
                  bit_cnt        <= '0;
                  state          <= BITS;
               end
            end
            BITS: begin
               if (!bus.frame_active) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
                  bit_cnt  <= '0;
               end else if (bus.sdi_valid) begin
                  shreg <= {shreg[DATA_W-3:0], bus.sdi};
                  // last bit goes straight to byte_out: one-cycle latency
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt              <= '0;
                     bus.byte_out         <= {shreg, bus.sdi};
                     bus.shift_en         <= 1'b1;
                     bus.transaction_done <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_serial_frontend.sv
// Bench for mem_serial_frontend: counter vector table, scoreboarded
// byte frames, abort and mid-frame reset sequences.
module tb_mem_serial_frontend;

   logic clk = 1'b0;
   logic reset;
   logic loop;
   logic clr_drv;
   logic inc_drv;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int t0       = 0;

   logic [7:0] exp_q[$];
   int         pulse_q[$];

   typedef struct {
      logic       clr;
      logic       inc;
      logic [2:0] cnt;
      logic       done;
   } cnt_vec_t;

   cnt_vec_t tbl[10];

   always #5 clk = ~clk;

   mem_serial_frontend_if #(.DATA_W(8)) ifc();

   assign ifc.tr_increament = loop ? ifc.transaction_done : inc_drv;
   assign ifc.tr_clear      = loop ? ifc.tr_done_4 : clr_drv;

   mem_serial_frontend #(
      .DATA_W   (8),
      .TR_COUNT (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // scoreboard: every shift_en pulse must match the oldest queued byte
   always begin
      @(posedge clk);
      #1;
      if (ifc.shift_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse actual=%0h expected=none",
                     ifc.byte_out);
         end else begin
            chk("byte_out", ifc.byte_out, exp_q.pop_front());
            chk("tdone_with_shift", ifc.transaction_done, 1);
            pulse_q.push_back(cyc);
         end
      end else if (ifc.transaction_done) begin
         checks++;
         failures++;
         $display("FAIL tdone_alone actual=1 expected=0");
      end
   end

   task automatic chk_pulse(input int exp);
      if (pulse_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL pulse_missing actual=none expected=%0d", exp);
      end else begin
         chk("pulse_cycle", pulse_q.pop_front() - t0, exp);
      end
   endtask

   task automatic start_frame(input logic cmd, input bit tog);
      ifc.frame_active = 1'b1;
      ifc.sdi          = cmd;
      ifc.sdi_valid    = !tog;
      step();
      t0 = cyc;
      chk("busy_frame", ifc.busy, 1);
      ifc.sdi_valid = 1'b1;
      step();
   endtask

   task automatic send_bits(input logic [7:0] b, input int n,
                            input bit tog, input bit push);
      if (push) exp_q.push_back(b);
      for (int i = 7; i > 7 - n; i--) begin
         if (tog) begin
            ifc.sdi_valid = 1'b0;
            ifc.sdi       = ~b[i];
            step();
         end
         ifc.sdi       = b[i];
         ifc.sdi_valid = 1'b1;
         step();
      end
   endtask

   initial begin
      tbl[0] = '{1'b0, 1'b1, 3'd1, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 3'd2, 1'b0};
      tbl[2] = '{1'b1, 1'b1, 3'd0, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 3'd1, 1'b0};
      tbl[4] = '{1'b0, 1'b1, 3'd2, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 3'd3, 1'b0};
      tbl[6] = '{1'b0, 1'b1, 3'd4, 1'b1};
      tbl[7] = '{1'b0, 1'b1, 3'd4, 1'b1};
      tbl[8] = '{1'b0, 1'b0, 3'd4, 1'b1};
      tbl[9] = '{1'b1, 1'b0, 3'd0, 1'b0};

      reset            = 1'b1;
      loop             = 1'b0;
      clr_drv          = 1'b0;
      inc_drv          = 1'b0;
      ifc.frame_active = 1'b0;
      ifc.sdi          = 1'b0;
      ifc.sdi_valid    = 1'b0;
      repeat (2) step();
      chk("rst_byte_out", ifc.byte_out, 0);
      chk("rst_shift_en", ifc.shift_en, 0);
      chk("rst_tdone", ifc.transaction_done, 0);
      chk("rst_tr_done_4", ifc.tr_done_4, 0);
      chk("rst_rw", ifc.read_write, 0);
      chk("rst_busy", ifc.busy, 0);
      chk("rst_count", dut.u_tr.count, 0);
      reset = 1'b0;
      step();
      chk("idle_busy", ifc.busy, 0);

      // counter table, including clear+increment at count 2
      for (int i = 0; i < 10; i++) begin
         logic prev_done;
         prev_done = (i == 0) ? 1'b0 : tbl[i-1].done;
         clr_drv   = tbl[i].clr;
         inc_drv   = tbl[i].inc;
         #1;
         chk("done_no_comb", ifc.tr_done_4, prev_done);
         step();
         chk("tbl_count", dut.u_tr.count, tbl[i].cnt);
         chk("tbl_done", ifc.tr_done_4, tbl[i].done);
      end
      clr_drv = 1'b0;
      inc_drv = 1'b0;
      step();

      // write frame with loopback controller
      loop = 1'b1;
      start_frame(1'b1, 1'b0);
      chk("wr_rw", ifc.read_write, 1);
      send_bits(8'hA5, 8, 1'b0, 1'b1);
      send_bits(8'h3C, 8, 1'b0, 1'b1);
      send_bits(8'h00, 8, 1'b0, 1'b1);
      send_bits(8'hFF, 8, 1'b0, 1'b1);
      ifc.sdi_valid = 1'b0;
      chk("loop_done_pre", ifc.tr_done_4, 0);
      step();
      chk("loop_done_hi", ifc.tr_done_4, 1);
      step();
      chk("loop_done_lo", ifc.tr_done_4, 0);
      chk("loop_count0", dut.u_tr.count, 0);
      chk_pulse(9);
      chk_pulse(17);
      chk_pulse(25);
      chk_pulse(33);
      ifc.frame_active = 1'b0;
      step();
      chk("wr_end_busy", ifc.busy, 0);
      loop = 1'b0;

      // read frame, sdi_valid toggling
      start_frame(1'b0, 1'b1);
      chk("rd_rw", ifc.read_write, 0);
      send_bits(8'h96, 8, 1'b1, 1'b1);
      ifc.sdi_valid = 1'b0;
      step();
      chk("rd_hold", ifc.byte_out, 8'h96);
      chk("rd_one_pulse", ifc.shift_en, 0);
      step();
      chk_pulse(17);
      ifc.frame_active = 1'b0;
      step();

      // abort after 5 bits of byte 2
      loop = 1'b1;
      start_frame(1'b1, 1'b0);
      send_bits(8'h5A, 8, 1'b0, 1'b1);
      send_bits(8'hF0, 5, 1'b0, 1'b0);
      chk("ab_cnt_pre", dut.u_tr.count, 1);
      ifc.frame_active = 1'b0;
      step();
      chk("ab_busy", ifc.busy, 0);
      chk("ab_state", dut.state, 0);
      chk("ab_count", dut.u_tr.count, 0);
      chk("ab_rw", ifc.read_write, 1);
      chk("ab_no_pulse", ifc.shift_en, 0);
      ifc.sdi_valid = 1'b0;
      repeat (3) step();
      loop = 1'b0;
      chk_pulse(9);
      chk("ab_byte_hold", ifc.byte_out, 8'h5A);

      // reset during bit 3
      start_frame(1'b1, 1'b0);
      send_bits(8'hE0, 2, 1'b0, 1'b0);
      ifc.sdi = 1'b1;
      reset   = 1'b1;
      step();
      chk("mr_byte_out", ifc.byte_out, 0);
      chk("mr_shift_en", ifc.shift_en, 0);
      chk("mr_rw", ifc.read_write, 0);
      chk("mr_busy", ifc.busy, 0);
      chk("mr_count", dut.u_tr.count, 0);
      reset            = 1'b0;
      ifc.frame_active = 1'b0;
      ifc.sdi_valid    = 1'b0;
      repeat (2) step();
      chk("mr_idle", ifc.busy, 0);
      start_frame(1'b1, 1'b0);
      send_bits(8'h69, 8, 1'b0, 1'b1);
      ifc.sdi_valid = 1'b0;
      step();
      chk_pulse(9);
      chk("mr_rw_new", ifc.read_write, 1);
      ifc.frame_active = 1'b0;
      repeat (3) step();

      chk("sb_empty", exp_q.size(), 0);
      chk("pulses_empty", pulse_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_serial_frontend.md
MEM_SERIAL_FRONTEND -- requirements
Module: mem_serial_frontend

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the bits per transaction (byte width).
REQ-002 Parameter TR_COUNT, default 4, SHALL set the transactions per address or data word.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 frame_active  input  1  SHALL be high for the duration of a serial frame.
REQ-006 sdi  input  1  SHALL be the serial data bit, MSB first.
REQ-007 sdi_valid  input  1  SHALL qualify sdi; one bit is accepted per cycle while high.
REQ-008 tr_clear  input  1  SHALL be the controller request to zero the transaction counter.
REQ-009 tr_increament  input  1  SHALL be the controller request to increment the transaction counter.
REQ-010 byte_out  output  DATA_W  SHALL be the last completed byte, held until the next byte completes.
REQ-011 shift_en  output  1  SHALL be the one-cycle pulse marking byte_out newly valid.
REQ-012 transaction_done  output  1  SHALL be the one-cycle pulse coincident with shift_en.
REQ-013 tr_done_4  output  1  SHALL be high whenever the transaction counter equals TR_COUNT.
REQ-014 read_write  output  1  SHALL be the latched frame command (1 = write, 0 = read).
REQ-015 busy  output  1  SHALL be high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, CMD, BITS.
REQ-017 IDLE SHALL go to CMD on the cycle frame_active is sampled high.
REQ-018 In CMD, the first accepted bit (sdi_valid=1) SHALL be latched into read_write, and the FSM SHALL go to BITS.
REQ-019 In BITS, each accepted bit SHALL shift into a DATA_W shift register, MSB first, and increment a bit counter.
REQ-020 On the DATA_W-th accepted bit, the next cycle SHALL load byte_out, pulse shift_en and transaction_done for exactly one cycle, and clear the bit counter; the FSM SHALL remain in BITS.
REQ-021 Latency from the final sdi bit being accepted to the shift_en pulse SHALL be exactly 1 cycle.
REQ-022 frame_active low in CMD or BITS SHALL return the FSM to IDLE next cycle, discard partial bits, suppress any pulse, and clear the transaction counter.
REQ-023 sdi_valid low SHALL stall the bit counter and shift register without loss.
REQ-024 The transaction counter SHALL be ceil(log2(TR_COUNT+1)) bits wide and SHALL saturate at TR_COUNT.
REQ-025 When tr_clear and tr_increament are both high, tr_clear SHALL win and the counter SHALL become 0.
REQ-026 tr_done_4 SHALL be decoded from the counter register only, with no combinational path from any input.
REQ-027 read_write SHALL hold its value until the next CMD bit is accepted, including through frame aborts.
REQ-028 A new frame SHALL be recognised only from IDLE; frame_active held high continuously SHALL be treated as one frame.

Reset
REQ-029 While reset is high, the block SHALL enter IDLE and clear the counters, byte_out, shift_en, transaction_done, read_write and busy to 0.
REQ-030 reset asserted mid-frame SHALL abandon the frame with no pulse, regardless of other inputs.
REQ-031 After reset deasserts, the block SHALL start a frame only when frame_active is sampled high in IDLE.

Structure
REQ-032 Package mem_if_pkg SHALL hold the state encoding (IDLE=2'b00, CMD=2'b01, BITS=2'b10), DATA_W and TR_COUNT defaults.
REQ-033 The transaction counter SHALL be the sub-module tr_counter (inputs clr, inc; output count and tr_done flag).
REQ-034 All outputs SHALL be registered except tr_done_4, which is decoded from a register.

Verification
REQ-035 Write frame, cmd bit 1 then bytes 0xA5, 0x3C, 0x00, 0xFF with sdi_valid held high -> read_write=1; four shift_en pulses 9/17/25/33 cycles after frame start; byte_out matches each byte.
REQ-036 Loop the controller back (tr_increament=transaction_done, tr_clear=tr_done_4) -> tr_done_4 high for exactly 1 cycle after the 4th byte; counter then 0.
REQ-037 Read frame with sdi_valid toggling 1-0-1-0 -> read_write=0; first byte completes after 16 data cycles; value intact.
REQ-038 Drop frame_active after 5 bits of byte 2 -> no pulse; IDLE next cycle; counter 0; read_write unchanged.
REQ-039 Assert tr_clear and tr_increament together at count 2 -> count 0; tr_done_4 stays low.
REQ-040 Assert reset during bit 3 of a byte -> all outputs 0 next cycle; a subsequent clean frame completes normally.
